regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with an init sweep, same-cycle write bypass,
// a pc-aliased register and a per-register write-back scoreboard.
module regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 3,
    parameter int PC_IDX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            we,
    input  logic [NREG-1:0]       wa0,
    input  logic [NREG-1:0]       wa1,
    input  logic [WIDTH-1:0]      wd0,
    input  logic [WIDTH-1:0]      wd1,
    input  logic [NRD*NREG-1:0]   ra,
    input  logic [WIDTH-1:0]      pc,
    input  logic [NREG-1:0]       set_pend,
    output logic [NRD*WIDTH-1:0]  rd,
    output logic [NRD-1:0]        pend,
    output logic                  ready
);

    localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {INIT, RUN} stateT;

    stateT               r_state;
    stateT               w_nextState;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_nextCnt;
    logic [WIDTH-1:0]    r_rf [NREG];
    logic [NREG-1:0]     r_pending;
    logic                w_run;
    logic [NREG-1:0]     w_wr0;
    logic [NREG-1:0]     w_wr1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (r_state == INIT) begin
            w_nextCnt = r_cnt + CW'(1);
            if (r_cnt == CW'(NREG - 1)) begin
                w_nextState = RUN;
            end
        end
    end

    assign ready = (r_state == RUN);

    // Write strobes are only live in RUN outside reset; they drive both the
    // array update and the read bypass so the two can never disagree.
    assign w_run = (r_state == RUN) && !reset;
    assign w_wr0 = (we[0] && w_run) ? wa0 : '0;
    assign w_wr1 = (we[1] && w_run) ? wa1 : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!reset) begin
                if (r_state == INIT) begin
                    if (r_cnt == CW'(i)) begin
                        r_rf[i]      <= '0;
                        r_pending[i] <= 1'b0;
                    end
                end else begin
                    if (w_wr1[i]) begin
                        r_rf[i] <= wd1;
                    end else if (w_wr0[i]) begin
                        r_rf[i] <= wd0;
                    end
                    if (set_pend[i]) begin
                        r_pending[i] <= 1'b1;
                    end else if (w_wr0[i] || w_wr1[i]) begin
                        r_pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Scanning from the top down lets the lowest set address bit win.
    always_comb begin
        rd   = '0;
        pend = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int i = NREG - 1; i >= 0; i--) begin
                if (ra[p*NREG + i]) begin
                    if (i == PC_IDX) begin
                        rd[p*WIDTH +: WIDTH] = pc;
                        pend[p]              = 1'b0;
                    end else if (w_wr1[i]) begin
                        rd[p*WIDTH +: WIDTH] = wd1;
                        pend[p]              = 1'b0;
                    end else if (w_wr0[i]) begin
                        rd[p*WIDTH +: WIDTH] = wd0;
                        pend[p]              = 1'b0;
                    end else begin
                        rd[p*WIDTH +: WIDTH] = r_rf[i];
                        pend[p]              = r_pending[i] && (r_state == RUN);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init sweep timing, write/bypass/pc table,
// scoreboard sequencing and reset during the sweep.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic [1:0]  we;
    logic [31:0] wa0, wa1, wd0, wd1;
    logic [95:0] ra;
    logic [31:0] pc;
    logic [31:0] set_pend;
    logic [95:0] rd;
    logic [2:0]  pend;
    logic        ready;

    int nAssert = 0;
    int nFail   = 0;

    typedef struct {
        string       name;
        logic [1:0]  we;
        logic [31:0] wa0, wa1, wd0, wd1;
        logic [95:0] ra;
        logic [31:0] pc;
        logic [31:0] setp;
        logic [95:0] expRd;
        logic [2:0]  expPend;
    } vecT;

    vecT vecs[$];

    regfile_mp #(.WIDTH(32), .NREG(32), .NRD(3), .PC_IDX(15)) dut (
        .clk(clk), .reset(reset), .we(we), .wa0(wa0), .wa1(wa1),
        .wd0(wd0), .wd1(wd1), .ra(ra), .pc(pc), .set_pend(set_pend),
        .rd(rd), .pend(pend), .ready(ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [1:0] vwe,
                          input logic [31:0] vwa0, input logic [31:0] vwa1,
                          input logic [31:0] vwd0, input logic [31:0] vwd1,
                          input logic [95:0] vra, input logic [31:0] vpc,
                          input logic [31:0] vsetp, input logic [95:0] vexpRd,
                          input logic [2:0] vexpPend);
        vecT v;
        v.name = name; v.we = vwe; v.wa0 = vwa0; v.wa1 = vwa1;
        v.wd0 = vwd0; v.wd1 = vwd1; v.ra = vra; v.pc = vpc;
        v.setp = vsetp; v.expRd = vexpRd; v.expPend = vexpPend;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vecT v);
        @(negedge clk);
        we = v.we; wa0 = v.wa0; wa1 = v.wa1; wd0 = v.wd0; wd1 = v.wd1;
        ra = v.ra; pc = v.pc; set_pend = v.setp;
        #1;
    endtask

    task automatic idleInputs();
        we = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        ra = '0; pc = '0; set_pend = '0;
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
        end
    endtask

    task automatic checkAllZero(input string tag);
        pc = '0;
        for (int i = 0; i < 32; i++) begin
            ra = {oh(i), oh(i), oh(i)};
            #1;
            checkOutput($sformatf("%s_rd_r%0d", tag, i), rd, 96'h0);
            checkOutput($sformatf("%s_pend_r%0d", tag, i), 96'(pend), 96'h0);
        end
        ra = '0;
    endtask

    initial begin
        int n;

        // cycle-by-cycle vectors; expected rd is {port2, port1, port0}
        addVec("wr_r2_r9_bypass", 2'b11, oh(2), oh(9), 32'h2, 32'h9,
               {32'h0, oh(9), oh(2)}, 32'h0, 32'h0, {32'h0, 32'h9, 32'h2}, 3'b000);
        addVec("multihot_ra_low", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {32'h0, oh(9), oh(2) | oh(9)}, 32'h0, 32'h0, {32'h0, 32'h9, 32'h2}, 3'b000);
        addVec("dual_wr_r3_port1_wins", 2'b11, oh(3), oh(3), 32'hAAAA0000, 32'h5555FFFF,
               {oh(3), oh(2), oh(3)}, 32'h0, 32'h0, {32'h5555FFFF, 32'h2, 32'h5555FFFF}, 3'b000);
        addVec("r3_stored_multihot_wr", 2'b01, oh(4) | oh(5), 32'h0, 32'h45, 32'h0,
               {oh(6), oh(4), oh(3)}, 32'h0, 32'h0, {32'h0, 32'h45, 32'h5555FFFF}, 3'b000);
        addVec("multihot_wr_stored", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {oh(3), oh(5), oh(4)}, 32'h0, 32'h0, {32'h5555FFFF, 32'h45, 32'h45}, 3'b000);
        addVec("pc_overrides_bypass", 2'b01, oh(15), 32'h0, 32'hDEAD, 32'h0,
               {32'h0, oh(15) | oh(20), oh(15)}, 32'h00001008, 32'h0,
               {32'h0, 32'h00001008, 32'h00001008}, 3'b000);
        addVec("set_pend_r7", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {oh(7), oh(15), oh(7)}, 32'h00001008, oh(7),
               {32'h0, 32'h00001008, 32'h0}, 3'b000);
        addVec("pend_r7_visible", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {oh(15), oh(7), oh(7)}, 32'h00001008, 32'h0,
               {32'h00001008, 32'h0, 32'h0}, 3'b011);
        addVec("wr_and_set_r7", 2'b10, 32'h0, oh(7), 32'h0, 32'h77,
               {32'h0, oh(8), oh(7)}, 32'h0, oh(7), {32'h0, 32'h0, 32'h77}, 3'b000);
        addVec("set_wins_multi_set", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {32'h0, oh(7), oh(7)}, 32'h0, oh(10) | oh(11), {32'h0, 32'h77, 32'h77}, 3'b011);
        addVec("plain_wr_r7_bypass", 2'b01, oh(7), 32'h0, 32'h78, 32'h0,
               {oh(11), oh(10), oh(7)}, 32'h0, 32'h0, {32'h0, 32'h0, 32'h78}, 3'b110);
        addVec("r7_cleared_we_off", 2'b00, oh(10), oh(10), 32'hBAD, 32'hBAD,
               {32'h0, oh(10), oh(7)}, 32'h0, 32'h0, {32'h0, 32'h0, 32'h78}, 3'b010);
        addVec("wr_r10_r11", 2'b11, oh(10), oh(11), 32'h100, 32'h110,
               {oh(3), oh(11), oh(10)}, 32'h0, 32'h0, {32'h5555FFFF, 32'h110, 32'h100}, 3'b000);
        addVec("r10_r11_cleared", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
               {oh(9), oh(11), oh(10)}, 32'h0, 32'h0, {32'h9, 32'h110, 32'h100}, 3'b000);

        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", 96'(ready), 96'h0);
        waitReady(n);
        checkOutput("ready_latency", 96'(n), 96'd32);
        checkAllZero("sweep1");

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput({vecs[k].name, "_rd"}, rd, vecs[k].expRd);
            checkOutput({vecs[k].name, "_pend"}, 96'(pend), 96'(vecs[k].expPend));
        end

        // leave r12 pending, then reset and watch the sweep ignore writes
        @(negedge clk);
        idleInputs();
        set_pend = oh(12);
        @(negedge clk);
        set_pend = '0;
        ra = {32'h0, oh(12), 32'h0};
        #1;
        checkOutput("pend_r12_run", 96'(pend), 96'h2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        we = 2'b11; wa0 = oh(25); wa1 = oh(25); wd0 = 32'h55; wd1 = 32'h66;
        set_pend = oh(25);
        ra = {32'h0, oh(12), oh(25)};
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput($sformatf("init_ready_%0d", k), 96'(ready), 96'h0);
            checkOutput($sformatf("init_no_bypass_%0d", k), {64'h0, rd[31:0]}, 96'h0);
            checkOutput($sformatf("init_pend_%0d", k), 96'(pend), 96'h0);
            @(posedge clk);
            @(negedge clk);
        end
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_rereset", 96'(ready), 96'h0);
        waitReady(n);
        checkOutput("ready_latency_rereset", 96'(n), 96'd32);
        checkAllZero("sweep2");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
